fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_stage.sv | 137 +++++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM state encoding, the PC increment and the instruction/address word type.
package fetch_stage_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam word_t PC_INC = 32'd4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO for the fetch stage: DEPTH entries of {pc, instr}, with a synchronous flush.
// The caller never pushes when full or pops when empty; pointers wrap modulo DEPTH.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic [63:0]   i_push_data,
    input  logic          i_pop,
    output logic [63:0]   o_head,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; o_empty gates every read, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, single-outstanding imem requests and a prefetch FIFO.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter  int          DEPTH    = 4,
    parameter  logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int          CW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    input  logic          halt_req,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    output logic          instr_valid,
    output logic [31:0]   instr_out,
    output logic [31:0]   instr_pc,
    input  logic          decode_ready,
    output logic [CW-1:0] fifo_count,
    output logic          halted
);

    state_t        r_state;
    word_t         r_pc;
    logic          r_inflight;
    word_t         r_inflight_pc;

    state_t        w_next_state;
    logic          w_issue;
    logic          w_room;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_fifo_head;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;

    // Count the outstanding request as occupied so its response always has a slot.
    assign w_room = (({1'b0, w_fifo_count} + (CW + 1)'(r_inflight)) < (CW + 1)'(DEPTH));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        case (r_state)
            BOOT: w_next_state = RUN;
            RUN: begin
                w_issue = !halt_req && w_room;
                if (halt_req) begin
                    w_next_state = HALT;
                end
            end
            HALT:    w_next_state = HALT;
            default: w_next_state = BOOT;
        endcase
        if (redirect_valid) begin
            w_issue      = 1'b0;
            w_next_state = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_state    <= w_next_state;
            r_inflight <= w_issue;
            if (redirect_valid) begin
                r_pc <= redirect_pc;
            end else if (w_issue) begin
                r_pc          <= r_pc + PC_INC;
                r_inflight_pc <= r_pc;
            end
        end
    end

    // A response landing in a redirect cycle belongs to the abandoned path.
    assign w_resp = r_inflight && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    logic w_bypass;

    always_comb begin
        w_bypass    = w_resp && w_fifo_empty;
        instr_valid = !w_fifo_empty || w_bypass;
        w_pop       = !w_fifo_empty && decode_ready && !redirect_valid;
        w_push      = w_resp && !(w_bypass && decode_ready);
        instr_out   = '0;
        instr_pc    = '0;
        if (w_bypass) begin
            instr_out = imem_rdata;
            instr_pc  = r_inflight_pc;
        end else if (!w_fifo_empty) begin
            instr_out = w_fifo_head[31:0];
            instr_pc  = w_fifo_head[63:32];
        end
    end
`else
    always_comb begin
        instr_valid = !w_fifo_empty;
        w_pop       = !w_fifo_empty && decode_ready && !redirect_valid;
        w_push      = w_resp;
        instr_out   = '0;
        instr_pc    = '0;
        if (!w_fifo_empty) begin
            instr_out = w_fifo_head[31:0];
            instr_pc  = w_fifo_head[63:32];
        end
    end
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (redirect_valid),
        .i_push      (w_push),
        .i_push_data ({r_inflight_pc, imem_rdata}),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign imem_req   = w_issue;
    assign imem_addr  = r_pc;
    assign fifo_count = w_fifo_count;
    assign halted     = (r_state == HALT);

endmodule
